// File: rtl/subservient_dbg_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : subservient_dbg_bridge
//  Brief    : Bridges the Caravel management Wishbone slave port onto the
//             subservient debug bus. It also holds the debug_mode and
//             core-reset control bits, plus sticky error status.
//  Revision : 1.0 - initial release
// ============================================================================
module subservient_dbg_bridge #(
    parameter int unsigned TIMEOUT_CYCLES   = 255,
    parameter bit          RST_HOLD_DEFAULT = 1'b1,
    parameter logic [31:0] ERR_DATA         = 32'hDEADBEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] o_wb_dbg_adr,
    output logic [31:0] o_wb_dbg_dat,
    output logic [3:0]  o_wb_dbg_sel,
    output logic        o_wb_dbg_we,
    output logic        o_wb_dbg_stb,
    input  logic [31:0] i_wb_dbg_rdt,
    input  logic        i_wb_dbg_ack,
    output logic        o_debug_mode,
    output logic        o_core_rst
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic [1:0]  CTRL_RESET    = {RST_HOLD_DEFAULT, 1'b0};

    state_t      state;
    logic [1:0]  ctrl;          // [0] debug_mode, [1] core_rst
    logic [1:0]  sticky;        // [0] timeout,    [1] mode error
    logic [31:0] last_rdt;
    logic [15:0] tmo_cnt;
    logic        host_gone;     // host abandoned the cycle while it was in flight

    logic        req;
    logic        csr_hit;
    logic        busy;
    logic [15:0] tmo_next;
    logic [31:0] csr_rdata;

    // Address bits outside the decoded window are deliberately ignored.
    logic unused_adr_bits;
    assign unused_adr_bits = &{1'b0, wbs_adr_i[31:24], wbs_adr_i[1:0]};

    assign req          = wbs_cyc_i & wbs_stb_i;
    assign csr_hit      = wbs_adr_i[23];
    assign busy         = (state != IDLE);
    assign tmo_next     = tmo_cnt + 16'd1;
    assign o_debug_mode = ctrl[0];
    assign o_core_rst   = ctrl[1];

    // CSR read multiplexer, selected by word address within the CSR block.
    always_comb begin
        csr_rdata = 32'h0;
        case (wbs_adr_i[3:2])
            2'd0:    csr_rdata = {30'h0, ctrl};
            2'd1:    csr_rdata = {29'h0, busy, sticky};
            2'd2:    csr_rdata = last_rdt;
            default: csr_rdata = 32'h0;
        endcase
    end

    // Transaction FSM, CSR storage and all registered outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            ctrl         <= CTRL_RESET;
            sticky       <= 2'b00;
            last_rdt     <= 32'h0;
            tmo_cnt      <= 16'h0;
            host_gone    <= 1'b0;
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= 32'h0;
            o_wb_dbg_adr <= 32'h0;
            o_wb_dbg_dat <= 32'h0;
            o_wb_dbg_sel <= 4'h0;
            o_wb_dbg_we  <= 1'b0;
            o_wb_dbg_stb <= 1'b0;
        end else begin
            wbs_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        host_gone <= 1'b0;
                        if (csr_hit) begin
                            // CSR access completes here; only byte lane 0 is writable.
                            if (!wbs_we_i) begin
                                wbs_dat_o <= csr_rdata;
                            end else if (wbs_sel_i[0]) begin
                                case (wbs_adr_i[3:2])
                                    2'd0:    ctrl   <= wbs_dat_i[1:0];
                                    2'd1:    sticky <= sticky & ~wbs_dat_i[1:0];
                                    default: ;
                                endcase
                            end
                            state <= RESP;
                        end else if (ctrl[0]) begin
                            o_wb_dbg_adr <= {8'h0, wbs_adr_i[23:2], 2'b00};
                            o_wb_dbg_dat <= wbs_dat_i;
                            o_wb_dbg_sel <= wbs_sel_i;
                            o_wb_dbg_we  <= wbs_we_i;
                            o_wb_dbg_stb <= 1'b1;
                            tmo_cnt      <= 16'h0;
                            state        <= REQ;
                        end else begin
                            // Debug window touched while the core owns the bus.
                            sticky[1] <= 1'b1;
                            wbs_dat_o <= ERR_DATA;
                            state     <= RESP;
                        end
                    end
                end
                REQ: begin
                    if (!wbs_cyc_i) begin
                        host_gone <= 1'b1;
                    end
                    // Ack takes priority over a timeout landing on the same edge.
                    if (i_wb_dbg_ack) begin
                        o_wb_dbg_stb <= 1'b0;
                        if (!o_wb_dbg_we) begin
                            wbs_dat_o <= i_wb_dbg_rdt;
                            last_rdt  <= i_wb_dbg_rdt;
                        end
                        state <= RESP;
                    end else if (tmo_next == TIMEOUT_LIMIT) begin
                        o_wb_dbg_stb <= 1'b0;
                        sticky[0]    <= 1'b1;
                        wbs_dat_o    <= ERR_DATA;
                        state        <= RESP;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end
                RESP: begin
                    wbs_ack_o <= ~host_gone;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_subservient_dbg_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_subservient_dbg_bridge
//  Brief    : Directed self-checking bench for subservient_dbg_bridge with a
//             programmable debug-bus responder and a read-data scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_subservient_dbg_bridge;

    localparam logic [31:0] CSR_CTRL   = 32'h0080_0000;
    localparam logic [31:0] CSR_STATUS = 32'h0080_0004;
    localparam logic [31:0] CSR_LAST   = 32'h0080_0008;
    localparam logic [31:0] CSR_RSVD   = 32'h0080_000C;
    localparam logic [31:0] ERR        = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, wdat = 32'h0;
    logic        ack_o;
    logic [31:0] dat_o;
    logic [31:0] dbg_adr, dbg_dat;
    logic [3:0]  dbg_sel;
    logic        dbg_we, dbg_stb;
    logic [31:0] dbg_rdt = 32'h0;
    logic        dbg_ack = 1'b0;
    logic        debug_mode, core_rst;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // Responder configuration
    int          resp_lat   = 3;
    bit          resp_never = 1'b0;
    logic [31:0] resp_rdt   = 32'h0;
    int          wait_cnt   = 0;

    // Snapshot of the debug bus in the first cycle of a transfer
    logic        snap_stb, snap_we;
    logic [31:0] snap_adr, snap_dat;
    logic [3:0]  snap_sel;
    int          stb_hi;

    always #5 clk = ~clk;

    subservient_dbg_bridge #(
        .TIMEOUT_CYCLES   (8),
        .RST_HOLD_DEFAULT (1'b1),
        .ERR_DATA         (32'hDEADBEEF)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wbs_cyc_i    (cyc),
        .wbs_stb_i    (stb),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (wdat),
        .wbs_ack_o    (ack_o),
        .wbs_dat_o    (dat_o),
        .o_wb_dbg_adr (dbg_adr),
        .o_wb_dbg_dat (dbg_dat),
        .o_wb_dbg_sel (dbg_sel),
        .o_wb_dbg_we  (dbg_we),
        .o_wb_dbg_stb (dbg_stb),
        .i_wb_dbg_rdt (dbg_rdt),
        .i_wb_dbg_ack (dbg_ack),
        .o_debug_mode (debug_mode),
        .o_core_rst   (core_rst)
    );

    // Debug-bus responder: one-cycle ack resp_lat cycles after stb is seen.
    always @(posedge clk) begin
        #1;
        if (dbg_ack) begin
            dbg_ack = 1'b0;
        end else if (dbg_stb && !resp_never) begin
            if (wait_cnt >= resp_lat - 1) begin
                dbg_ack  = 1'b1;
                dbg_rdt  = resp_rdt;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One host transfer; reads push the expected data and pop it at ack.
    task automatic xfer(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input bit wr, input logic [3:0] s, input int exp_cycles,
                        input logic [31:0] exp_rd);
        int          cycles;
        bit          got;
        logic [31:0] rd;
        logic [31:0] exp_pop;
        cycles = 0;
        got    = 1'b0;
        rd     = 32'h0;
        stb_hi = 0;
        if (!wr) exp_q.push_back(exp_rd);
        adr = a; wdat = d; we = wr; sel = s; cyc = 1'b1; stb = 1'b1;
        while (!got && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
            if (dbg_stb) stb_hi++;
            if (cycles == 1) begin
                snap_stb = dbg_stb; snap_we = dbg_we; snap_adr = dbg_adr;
                snap_dat = dbg_dat; snap_sel = dbg_sel;
            end
            if (ack_o) begin
                got = 1'b1;
                rd  = dat_o;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check({tag, " ack"}, {31'h0, got}, 32'h1);
        check({tag, " latency"}, cycles, exp_cycles);
        if (!wr) begin
            exp_pop = exp_q.pop_front();
            check({tag, " rdata"}, rd, exp_pop);
        end
        if (got) begin
            @(posedge clk); #1;
            check({tag, " ack one cycle"}, {31'h0, ack_o}, 32'h0);
        end
    endtask

    initial begin
        int acks;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset ack", {31'h0, ack_o}, 32'h0);
        check("reset dat_o", dat_o, 32'h0);
        check("reset dbg_stb", {31'h0, dbg_stb}, 32'h0);
        check("reset dbg_adr", dbg_adr, 32'h0);
        check("reset core_rst", {31'h0, core_rst}, 32'h1);
        check("reset debug_mode", {31'h0, debug_mode}, 32'h0);
        rst = 1'b0;

        xfer("status idle", CSR_STATUS, 32'h0, 1'b0, 4'hF, 2, 32'h0);
        xfer("ctrl wr", CSR_CTRL, 32'h1, 1'b1, 4'hF, 2, 32'h0);
        check("debug_mode set", {31'h0, debug_mode}, 32'h1);
        check("core_rst released", {31'h0, core_rst}, 32'h0);
        xfer("ctrl rd", CSR_CTRL, 32'h0, 1'b0, 4'hF, 2, 32'h1);

        // Byte 0 not selected -> ignored
        xfer("ctrl wr sel0 off", CSR_CTRL, 32'h3, 1'b1, 4'hE, 2, 32'h0);
        xfer("ctrl rd unchanged", CSR_CTRL, 32'h0, 1'b0, 4'hF, 2, 32'h1);
        xfer("rsvd wr", CSR_RSVD, 32'hFF, 1'b1, 4'hF, 2, 32'h0);
        xfer("rsvd rd", CSR_RSVD, 32'h0, 1'b0, 4'hF, 2, 32'h0);

        // Debug write, responder latency 3
        resp_lat = 3;
        xfer("dbg wr", 32'h0000_0010, 32'h1234_5678, 1'b1, 4'hF, 5, 32'h0);
        check("dbg wr stb", {31'h0, snap_stb}, 32'h1);
        check("dbg wr adr", snap_adr, 32'h10);
        check("dbg wr dat", snap_dat, 32'h1234_5678);
        check("dbg wr we", {31'h0, snap_we}, 32'h1);
        check("dbg wr sel", {28'h0, snap_sel}, 32'hF);
        check("dbg wr stb cycles", stb_hi, 3);

        // Debug reads
        resp_lat = 2; resp_rdt = 32'hCAFE_F00D;
        xfer("dbg rd", 32'h0000_0040, 32'h0, 1'b0, 4'hF, 4, 32'hCAFE_F00D);
        check("dbg rd adr", snap_adr, 32'h40);
        check("dbg rd we", {31'h0, snap_we}, 32'h0);
        xfer("last_rdt", CSR_LAST, 32'h0, 1'b0, 4'hF, 2, 32'hCAFE_F00D);

        resp_lat = 1; resp_rdt = 32'h0BAD_F00D;
        xfer("dbg rd decode", 32'hFF00_0047, 32'h0, 1'b0, 4'h3, 3, 32'h0BAD_F00D);
        check("dbg decode adr", snap_adr, 32'h0000_0044);
        check("dbg decode sel", {28'h0, snap_sel}, 32'h3);

        // Ack on the very cycle the counter reaches the limit
        resp_lat = 8; resp_rdt = 32'h5A5A_5A5A;
        xfer("dbg rd edge ack", 32'h0000_0080, 32'h0, 1'b0, 4'hF, 10, 32'h5A5A_5A5A);
        check("edge ack stb cycles", stb_hi, 8);
        xfer("status after edge", CSR_STATUS, 32'h0, 1'b0, 4'hF, 2, 32'h0);

        // Timeout
        resp_never = 1'b1;
        xfer("dbg timeout", 32'h0000_0020, 32'h0, 1'b0, 4'hF, 10, ERR);
        check("timeout stb cycles", stb_hi, 8);
        xfer("status timeout", CSR_STATUS, 32'h0, 1'b0, 4'hF, 2, 32'h1);
        xfer("status w1c", CSR_STATUS, 32'h1, 1'b1, 4'hF, 2, 32'h0);
        xfer("status cleared", CSR_STATUS, 32'h0, 1'b0, 4'hF, 2, 32'h0);
        resp_never = 1'b0;

        // Mode error
        xfer("ctrl mode off", CSR_CTRL, 32'h0, 1'b1, 4'hF, 2, 32'h0);
        xfer("dbg mode err", 32'h0000_0030, 32'h0, 1'b0, 4'hF, 2, ERR);
        check("mode err stb", stb_hi, 0);
        xfer("status mode err", CSR_STATUS, 32'h0, 1'b0, 4'hF, 2, 32'h2);

        // Host abandons the cycle: debug access completes, no host ack
        xfer("ctrl mode on", CSR_CTRL, 32'h1, 1'b1, 4'hF, 2, 32'h0);
        resp_lat = 4; resp_rdt = 32'h1357_2468;
        adr = 32'h0000_0050; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        check("drop stb up", {31'h0, dbg_stb}, 32'h1);
        cyc = 1'b0; stb = 1'b0;
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ack_o) acks++;
        end
        check("drop no ack", acks, 0);
        check("drop stb done", {31'h0, dbg_stb}, 32'h0);
        xfer("drop last_rdt", CSR_LAST, 32'h0, 1'b0, 4'hF, 2, 32'h1357_2468);

        // Reset on the 2nd REQ cycle
        resp_never = 1'b1;
        adr = 32'h0000_0060; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        check("rst stb up", {31'h0, dbg_stb}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst stb dropped", {31'h0, dbg_stb}, 32'h0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack_o) acks++;
        end
        check("rst no ack", acks, 0);
        check("rst core_rst", {31'h0, core_rst}, 32'h1);
        check("rst debug_mode", {31'h0, debug_mode}, 32'h0);
        resp_never = 1'b0;
        xfer("rst ctrl rd", CSR_CTRL, 32'h0, 1'b0, 4'hF, 2, 32'h2);
        xfer("rst status rd", CSR_STATUS, 32'h0, 1'b0, 4'hF, 2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/subservient_dbg_bridge.md
Name: subservient_dbg_bridge

Overview:
- Wishbone initiator that drives the subservient debug port (i_wb_dbg_* / o_wb_dbg_*) from the Caravel management-SoC Wishbone slave port (wbs_*).
- Lets firmware halt the core, load or inspect core SRAM through the debug bus, then release the core.
- Sits in the user project top, between the wbs_* pins and the subservient instance.
- Also owns the debug_mode and core-reset control registers.

Parameters:
- TIMEOUT_CYCLES, 255: debug-bus cycles to wait for i_wb_dbg_ack before aborting (1..65535).
- RST_HOLD_DEFAULT, 1: reset value of CTRL.core_rst.
- ERR_DATA, 32'hDEADBEEF: read data returned on error or timeout.

Ports:
- wb_clk_i  in  1  clock (the only clock in the block).
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  host Wishbone control.
- wbs_sel_i  in  4  host byte selects.
- wbs_adr_i  in  32  host address.
- wbs_dat_i  in  32  host write data.
- wbs_ack_o  out  1  host acknowledge.
- wbs_dat_o  out  32  host read data.
- o_wb_dbg_adr  out  32  debug-bus address.
- o_wb_dbg_dat  out  32  debug-bus write data.
- o_wb_dbg_sel  out  4  debug-bus byte selects.
- o_wb_dbg_we  out  1  debug-bus write enable.
- o_wb_dbg_stb  out  1  debug-bus strobe.
- i_wb_dbg_rdt  in  32  debug-bus read data.
- i_wb_dbg_ack  in  1  debug-bus acknowledge.
- o_debug_mode  out  1  connects to subservient i_debug_mode.
- o_core_rst  out  1  ORed into the subservient i_rst.

Behaviour:
- Reset values: wbs_ack_o=0; wbs_dat_o=0; all o_wb_dbg_* =0; o_debug_mode=0; o_core_rst=RST_HOLD_DEFAULT; STATUS=0; FSM=IDLE.
- Address decode:
  - wbs_adr_i[23]=0: debug window. o_wb_dbg_adr = {8'h0, wbs_adr_i[23:2], 2'b00}.
  - wbs_adr_i[23]=1: CSR block, register selected by wbs_adr_i[3:2].
- CSR map:
  - 0x0 CTRL (RW): bit0 debug_mode, bit1 core_rst; other bits read 0.
  - 0x1 STATUS: bit0 sticky timeout, bit1 sticky mode-error, bit2 busy. Write-1-to-clear on bits 1:0.
  - 0x2 LAST_RDT (RO): last debug read data.
  - 0x3 reads 0, writes ignored.
- CSR writes honour wbs_sel_i for byte 0 only.
- FSM states IDLE, REQ, RESP.
- IDLE:
  - If cyc&stb with a CSR address: perform the access, go to RESP. Ack is asserted in the 2nd cycle after the request is first seen.
  - If cyc&stb with a debug address and debug_mode=1: latch address, data, sel and we; assert o_wb_dbg_stb the next cycle; go to REQ.
  - If cyc&stb with a debug address and debug_mode=0: no debug cycle; set STATUS.bit1; return ERR_DATA; go to RESP.
- REQ:
  - Hold o_wb_dbg_stb and all latched fields stable until i_wb_dbg_ack.
  - On ack: drop stb the next cycle, capture i_wb_dbg_rdt into wbs_dat_o and LAST_RDT, go to RESP.
  - The 16-bit timeout counter starts at 0 on entry and increments each REQ cycle.
  - Timeout: when the counter reaches TIMEOUT_CYCLES with no ack, drop stb, set STATUS.bit0, wbs_dat_o=ERR_DATA, go to RESP.
  - An ack arriving in the same cycle the counter reaches TIMEOUT_CYCLES counts as success.
- RESP:
  - wbs_ack_o=1 for exactly one cycle, then IDLE.
  - If the host dropped cyc while in REQ, the debug cycle still completes but wbs_ack_o stays 0 in RESP.
- Ack is registered, never combinational.
- Debug-path latency from stb to ack: 1 + debug ack latency + 1 cycles.
- At most one outstanding transaction; a new request is only accepted in IDLE.
- STATUS.busy = (FSM != IDLE).
- wbs_dat_o holds its value until the next completed read.
- Writes return the previous wbs_dat_o value; the host must ignore it.
- Reset asserted mid-transaction:
  - Next cycle o_wb_dbg_stb=0 and FSM=IDLE; no ack is issued.
  - CTRL returns to its reset values, including core_rst=RST_HOLD_DEFAULT.
- Clearing CTRL.debug_mode while in REQ does not abort the cycle in flight.

Test Plan:
- After reset: o_core_rst=1, o_debug_mode=0. Write CTRL=0x1 -> o_debug_mode=1, o_core_rst=0; read CTRL returns 0x1; ack in the 2nd cycle after the request.
- debug_mode=1, write 0x12345678 with sel=0xF at adr 0x0000_0010:
  - o_wb_dbg_stb=1 with adr=0x10, dat=0x12345678, we=1.
  - Responder acks after 3 cycles -> wbs_ack_o one cycle later, for exactly 1 cycle.
- Debug read at adr 0x0000_0040 with responder rdt=0xCAFEF00D -> wbs_dat_o=0xCAFEF00D and LAST_RDT=0xCAFEF00D.
- TIMEOUT_CYCLES=8 with a responder that never acks:
  - o_wb_dbg_stb drops after 8 REQ cycles.
  - wbs_ack_o=1 with 0xDEADBEEF; STATUS reads 0x1.
  - Writing 0x1 to STATUS -> STATUS reads 0x0.
- debug_mode=0, debug read -> o_wb_dbg_stb never rises; ack with 0xDEADBEEF; STATUS.bit1=1.
- Reset pulsed on the 2nd REQ cycle -> o_wb_dbg_stb=0 the next cycle; no wbs_ack_o; CTRL reads 0x2.
